paralelo_serial: RTL

PARALELO_SERIAL -- requirements
Module: paralelo_serial

---
 rtl/paralelo_serial.sv | 79 +++++++
 1 files changed

// File: rtl/paralelo_serial.sv
// Parallel-to-serial link transmitter: sends COM_COUNT sync bytes after reset, then one byte per 8 cycles.
// Serial output is MSB first. readyOut marks the one cycle in eight when dataIn/validIn are sampled.
module paralelo_serial #(
  parameter logic [7:0]  COM_CHAR  = 8'hBC,
  parameter logic [7:0]  IDLE_CHAR = 8'h7C,
  parameter int unsigned COM_COUNT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] dataIn,
  input  logic       validIn,
  output logic       dataOut,
  output logic       readyOut,
  output logic       activeOut
);

  typedef enum logic {SYNC = 1'b0, ACTIVE = 1'b1} state_t;

  localparam logic [3:0] COM_LAST = 4'(COM_COUNT);

  state_t     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] com_cnt_q, com_cnt_d;
  logic       data_q, data_d;

  logic load_pt;
  logic sync_done;

  assign load_pt   = (bit_cnt_q == 3'd7);
  assign sync_done = (com_cnt_q == COM_LAST);

  // Reset preloads the first COM byte, so the counter already counts it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= SYNC;
      shift_q   <= COM_CHAR;
      bit_cnt_q <= 3'd0;
      com_cnt_q <= 4'd1;
      data_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      com_cnt_q <= com_cnt_d;
      data_q    <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == SYNC && load_pt && sync_done) begin
      state_d = ACTIVE;
    end
  end

  always_comb begin
    data_d    = shift_q[7];
    bit_cnt_d = bit_cnt_q + 3'd1;
    shift_d   = shift_q << 1;
    com_cnt_d = com_cnt_q;
    if (load_pt) begin
      if (state_q == SYNC && !sync_done) begin
        shift_d   = COM_CHAR;
        com_cnt_d = com_cnt_q + 4'd1;
      end else begin
        shift_d = validIn ? dataIn : IDLE_CHAR;
      end
    end
  end

  always_comb begin
    readyOut  = load_pt && (state_q == ACTIVE || sync_done);
    activeOut = (state_q == ACTIVE);
  end

  assign dataOut = data_q;

endmodule
